// File: rtl/mod_n_divider.sv
// Run-time programmable mod-N clock divider: counts 0..D-1, emits a registered
// near-50% divided clock, a one-cycle wrap tick and the active divisor.
module mod_n_divider #(
    parameter int WIDTH       = 7,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic [WIDTH-1:0] count,
    output logic             clk_mod,
    output logic             tick,
    output logic [WIDTH-1:0] div_active
);

    localparam logic [WIDTH-1:0] RESET_DIV     = WIDTH'(DEFAULT_DIV);
    localparam logic             RESET_CLK_MOD = (DEFAULT_DIV == 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_mod_q, clk_mod_d;
    logic             tick_q, tick_d;
    logic             at_last;

    assign at_last = (count_q == div_q - WIDTH'(1));

    always_comb begin
        count_d      = count_q;
        div_d        = div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;

        if (clear) begin
            count_d = '0;
            if (pend_valid_q) begin
                div_d        = pend_div_q;
                pend_valid_d = 1'b0;
            end
        end else if (en) begin
            if (at_last) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (pend_valid_q) begin
                    div_d        = pend_div_q;
                    pend_valid_d = 1'b0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end

        // A load on a wrap/clear edge only arms the pending slot; the switch
        // above consumed the previous pending value, so this one waits.
        if (load && (div_in != '0)) begin
            pend_div_d   = div_in;
            pend_valid_d = 1'b1;
        end

        // With count and D held this reproduces the held value, so no
        // separate hold path is needed for en=0.
        clk_mod_d = (count_d >= (div_d >> 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            div_q        <= RESET_DIV;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            clk_mod_q    <= RESET_CLK_MOD;
            tick_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            div_q        <= div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            clk_mod_q    <= clk_mod_d;
            tick_q       <= tick_d;
        end
    end

    assign count      = count_q;
    assign div_active = div_q;
    assign clk_mod    = clk_mod_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_mod_n_divider.sv
// Directed bench for mod_n_divider: a cycle-level vector table followed by
// hand-written multi-cycle sequences for divisor changes, clear, gating and D=1.
module tb_mod_n_divider;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic [W-1:0] count;
    logic         clk_mod;
    logic         tick;
    logic [W-1:0] div_active;

    int checks = 0;
    int errors = 0;

    mod_n_divider #(.WIDTH(W), .DEFAULT_DIV(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clear      (clear),
        .load       (load),
        .div_in     (div_in),
        .count      (count),
        .clk_mod    (clk_mod),
        .tick       (tick),
        .div_active (div_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     reset;
        logic     en;
        logic     clear;
        logic     load;
        int       div_in;
        int       exp_count;
        int       exp_tick;
        int       exp_clk_mod;
        int       exp_div;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        en    = 1'b1;
        clear = 1'b0;
        load  = 1'b0;
    endtask

    task automatic pulse_load(input int d);
        load   = 1'b1;
        div_in = W'(d);
        step();
        load   = 1'b0;
    endtask

    task automatic run_until_tick(input string name, input int exp_edges, input int exp_div,
                                  output int edges);
        edges = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (tick) begin
                edges = i;
                break;
            end
        end
        chk({name, "_edges"}, edges, exp_edges);
        chk({name, "_div"}, int'(div_active), exp_div);
        chk({name, "_count"}, int'(count), 0);
    endtask

    // Assumes count just wrapped to 0; low_cnt is the hand-derived clk_mod low time.
    task automatic check_period(input string name, input int d, input int low_cnt, input int n);
        for (int j = 1; j <= n; j++) begin
            step();
            chk({name, "_count"}, int'(count), j % d);
            chk({name, "_tick"}, int'(tick), ((j % d) == 0) ? 1 : 0);
            chk({name, "_clkmod"}, int'(clk_mod), ((j % d) >= low_cnt) ? 1 : 0);
        end
    endtask

    initial begin
        int e;
        int total;

        // reset en clr load div  cnt tick clk div
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 100};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 0, 0, 100};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 3};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 0, 1, 3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 0, 1, 3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 0, 1, 3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 2};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 5, 0, 0, 0, 100};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 100};

        for (int v = 0; v < 16; v++) begin
            reset  = vecs[v].reset;
            en     = vecs[v].en;
            clear  = vecs[v].clear;
            load   = vecs[v].load;
            div_in = W'(vecs[v].div_in);
            step();
            chk($sformatf("vec%0d_count", v), int'(count), vecs[v].exp_count);
            chk($sformatf("vec%0d_tick", v), int'(tick), vecs[v].exp_tick);
            chk($sformatf("vec%0d_clkmod", v), int'(clk_mod), vecs[v].exp_clk_mod);
            chk($sformatf("vec%0d_div", v), int'(div_active), vecs[v].exp_div);
        end

        // Reset and default divide-by-100 over 300 enabled edges.
        reset = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; div_in = '0;
        repeat (3) step();
        chk("rst_count", int'(count), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_clkmod", int'(clk_mod), 0);
        chk("rst_div", int'(div_active), 100);
        idle();
        for (int k = 1; k <= 300; k++) begin
            step();
            chk("d100_count", int'(count), k % 100);
            chk("d100_tick", int'(tick), (k == 100 || k == 200 || k == 300) ? 1 : 0);
            chk("d100_clkmod", int'(clk_mod), ((k % 100) >= 50) ? 1 : 0);
        end

        // Runtime change to 10 at count 40, then to 7.
        repeat (40) step();
        chk("pre_load_count", int'(count), 40);
        pulse_load(10);
        chk("load10_div_old", int'(div_active), 100);
        run_until_tick("to10", 59, 10, e);
        chk("to10_clkmod", int'(clk_mod), 0);
        check_period("d10", 10, 5, 20);
        pulse_load(7);
        chk("load7_div_old", int'(div_active), 10);
        run_until_tick("to7", 9, 7, e);
        check_period("d7", 7, 3, 14);

        // Load edge cases.
        pulse_load(0);
        run_until_tick("load0", 6, 7, e);
        pulse_load(20);
        pulse_load(30);
        run_until_tick("last_wins", 5, 30, e);
        repeat (29) step();
        chk("pre_wrap_count", int'(count), 29);
        load = 1'b1; div_in = W'(12);
        step();
        load = 1'b0;
        chk("wrapload_tick", int'(tick), 1);
        chk("wrapload_div", int'(div_active), 30);
        run_until_tick("wrapload_old", 30, 12, e);
        run_until_tick("wrapload_new", 12, 12, e);

        // Clear at count 55 with 25 pending.
        pulse_load(100);
        run_until_tick("back100", 11, 100, e);
        pulse_load(25);
        repeat (54) step();
        chk("pre_clear_count", int'(count), 55);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count", int'(count), 0);
        chk("clear_div", int'(div_active), 25);
        chk("clear_tick", int'(tick), 0);
        chk("clear_clkmod", int'(clk_mod), 0);
        run_until_tick("after_clear", 25, 25, e);

        // Enable gating: 17 disabled cycles at count 30.
        pulse_load(100);
        run_until_tick("gate_setup", 24, 100, e);
        repeat (30) step();
        chk("gate_count", int'(count), 30);
        en = 1'b0;
        for (int g = 0; g < 17; g++) begin
            step();
            chk("gate_hold_count", int'(count), 30);
            chk("gate_hold_tick", int'(tick), 0);
            chk("gate_hold_clkmod", int'(clk_mod), 0);
        end
        en = 1'b1;
        run_until_tick("gate_resume", 70, 100, e);
        total = 30 + 17 + e;
        chk("gate_gap", total, 117);

        // D=1, then reset with a pending load.
        pulse_load(1);
        run_until_tick("to1", 99, 1, e);
        chk("d1_clkmod_first", int'(clk_mod), 1);
        for (int t = 0; t < 5; t++) begin
            step();
            chk("d1_tick", int'(tick), 1);
            chk("d1_clkmod", int'(clk_mod), 1);
            chk("d1_count", int'(count), 0);
        end
        pulse_load(50);
        chk("d1_pend_tick", int'(tick), 1);
        reset = 1'b1;
        step();
        chk("midrst_div", int'(div_active), 100);
        chk("midrst_count", int'(count), 0);
        chk("midrst_clkmod", int'(clk_mod), 0);
        chk("midrst_tick", int'(tick), 0);
        idle();
        run_until_tick("pend_lost", 100, 100, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
